svm_seq_ctrl: RTL
=================

SVM_SEQ_CTRL -- requirements
Module: svm_seq_ctrl

Interface
REQ-001 Parameter WIDTH_A, default 4, bits per input feature.
REQ-002 Parameter NUM_A, default 21, features per sample.
REQ-003 Parameter OUTWIDTH, default 14, width of the regression datapath result.
REQ-004 Parameter FRAC, default 10, fractional bits of the datapath result.
REQ-005 Parameter MAX_CLASS, default 3, highest legal class label.
REQ-006 Parameter SETTLE, default 2, range 1..15, cycles allowed for the combinational datapath to settle.
REQ-007 clk  in  1  single clock; all state changes on its rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 feat_valid  in  1  a feature beat is offered.
REQ-010 feat_data  in  WIDTH_A  unsigned feature value.
REQ-011 feat_last  in  1  beat is the final feature of its sample.
REQ-012 feat_ready  out  1  block accepts a beat this cycle.
REQ-013 inp  out  NUM_A*WIDTH_A  packed feature vector to the datapath; feature i at bits [(i+1)*WIDTH_A-1 : i*WIDTH_A].
REQ-014 dp_out  in  OUTWIDTH  unsigned fixed-point datapath result.
REQ-015 cls_valid  out  1  class result available.
REQ-016 cls_data  out  OUTWIDTH-FRAC  rounded, clamped class label.
REQ-017 cls_ready  in  1  consumer accepts the result.
REQ-018 frame_err  out  1  one-cycle pulse on a framing violation.
REQ-019 sample_cnt  out  16  completed classifications, wraps 0xFFFF->0.

Function
REQ-020 FSM states: LOAD, SETTLE, RESULT.
REQ-021 feat_ready shall be 1 only in LOAD.
REQ-022 In LOAD, each handshake (feat_valid & feat_ready) shall write feat_data into slot idx of the feature register and increment idx (0..NUM_A-1).
REQ-023 A handshake at idx==NUM_A-1 with feat_last=1 shall clear idx, load settle_cnt=SETTLE and enter SETTLE.
REQ-024 A handshake with feat_last=1 at idx<NUM_A-1, or feat_last=0 at idx==NUM_A-1, shall pulse frame_err for one cycle, clear idx, stay in LOAD, and discard the partial sample; feature register contents are don't-care until refilled.
REQ-025 inp shall mirror the feature register continuously and shall not change in SETTLE or RESULT.
REQ-026 In SETTLE, settle_cnt shall decrement each cycle; on the cycle it equals 1, the block shall capture the rounded result into cls_data, set cls_valid, and enter RESULT; total latency from the last-beat handshake to cls_valid=1 is SETTLE+1 cycles.
REQ-027 Rounding: I = dp_out[OUTWIDTH-1:FRAC], F = dp_out[FRAC-1:0]; R = I+1 if F > 2^(FRAC-1) (strictly greater), else R = I; computed at OUTWIDTH-FRAC+1 bits with no overflow.
REQ-028 Clamp: cls_data = MAX_CLASS if R > MAX_CLASS, else R.
REQ-029 In RESULT, cls_valid and cls_data shall hold stable until cls_valid & cls_ready; on that cycle, cls_valid shall clear, sample_cnt shall increment, and the FSM shall return to LOAD.
REQ-030 cls_ready while cls_valid=0 shall be ignored; feat_valid outside LOAD shall be ignored (no capture, no error).

Reset
REQ-031 rst=1 at any clock edge, including mid-sample or mid-RESULT, shall force: state=LOAD, idx=0, settle_cnt=0, feature register=0 (inp=0), cls_valid=0, cls_data=0, frame_err=0, sample_cnt=0; any pending result is lost.
REQ-032 Following the reset, feat_ready=1 on the first cycle after rst deasserts.

Verification
REQ-033 21 beats with values 0..20, last on beat 21, SETTLE=2, dp_out=0x0800 -> inp packs feature i=i, cls_valid 3 cycles after last beat, cls_data=2.
REQ-034 dp_out=0x0A00 -> cls_data=2 (exact half, no round-up); dp_out=0x0A01 -> cls_data=3.
REQ-035 dp_out=0x0E01 (3.5009) -> cls_data=3 (clamped); dp_out=0x1400 (5.0) -> cls_data=3.
REQ-036 feat_last on beat 5 -> frame_err pulses once, no cls_valid, next 21-beat sample classifies normally.
REQ-037 cls_ready held 0 for 10 cycles after cls_valid -> cls_data stable, feat_ready=0, extra feat_valid beats ignored; cls_ready=1 -> sample_cnt +1, LOAD.
REQ-038 rst pulsed after beat 12 -> all outputs at reset values; a fresh 21-beat sample then completes correctly.

Source files
------------

// File: rtl/svm_seq_ctrl.sv
// Sequencer around a combinational SVM regression datapath: collects one sample of features,
// waits for the datapath to settle, then rounds and clamps its result into a class label.
module svm_seq_ctrl #(
  parameter int unsigned WIDTH_A   = 4,
  parameter int unsigned NUM_A     = 21,
  parameter int unsigned OUTWIDTH  = 14,
  parameter int unsigned FRAC      = 10,
  parameter int unsigned MAX_CLASS = 3,
  parameter int unsigned SETTLE    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        feat_valid,
  input  logic [WIDTH_A-1:0]          feat_data,
  input  logic                        feat_last,
  output logic                        feat_ready,
  output logic [NUM_A*WIDTH_A-1:0]    inp,
  input  logic [OUTWIDTH-1:0]         dp_out,
  output logic                        cls_valid,
  output logic [OUTWIDTH-FRAC-1:0]    cls_data,
  input  logic                        cls_ready,
  output logic                        frame_err,
  output logic [15:0]                 sample_cnt
);

  localparam int unsigned IntW = OUTWIDTH - FRAC;
  localparam int unsigned IdxW = (NUM_A > 1) ? $clog2(NUM_A) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_A - 1);
  localparam logic [FRAC-1:0] HalfLsb = FRAC'(1) << (FRAC - 1);

  typedef enum logic [1:0] {StLoad, StSettle, StResult} state_e;

  state_e                     state_q, state_d;
  logic [IdxW-1:0]            idx_q, idx_d;
  logic [3:0]                 settle_q, settle_d;
  logic [NUM_A*WIDTH_A-1:0]   feat_q, feat_d;
  logic                       cls_valid_q, cls_valid_d;
  logic [IntW-1:0]            cls_data_q, cls_data_d;
  logic                       frame_err_q, frame_err_d;
  logic [15:0]                cnt_q, cnt_d;

  logic [IntW-1:0]            int_part;
  logic [FRAC-1:0]            frac_part;
  logic [IntW:0]              rounded;
  logic [IntW-1:0]            clamped;

  // Round half-down (exact .5 stays), one extra bit so I+1 cannot overflow before clamping.
  always_comb begin
    int_part  = dp_out[OUTWIDTH-1:FRAC];
    frac_part = dp_out[FRAC-1:0];
    rounded   = {1'b0, int_part} + (IntW + 1)'(frac_part > HalfLsb);
    if (rounded > (IntW + 1)'(MAX_CLASS)) begin
      clamped = IntW'(MAX_CLASS);
    end else begin
      clamped = rounded[IntW-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    settle_d    = settle_q;
    feat_d      = feat_q;
    cls_valid_d = cls_valid_q;
    cls_data_d  = cls_data_q;
    frame_err_d = 1'b0;
    cnt_d       = cnt_q;
    unique case (state_q)
      StLoad: begin
        if (feat_valid) begin
          feat_d[idx_q*WIDTH_A +: WIDTH_A] = feat_data;
          if (idx_q == LastIdx) begin
            idx_d = '0;
            if (feat_last) begin
              settle_d = 4'(SETTLE);
              state_d  = StSettle;
            end else begin
              frame_err_d = 1'b1;
            end
          end else if (feat_last) begin
            idx_d       = '0;
            frame_err_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StSettle: begin
        settle_d = settle_q - 4'd1;
        if (settle_q == 4'd1) begin
          cls_data_d  = clamped;
          cls_valid_d = 1'b1;
          state_d     = StResult;
        end
      end
      StResult: begin
        if (cls_ready) begin
          cls_valid_d = 1'b0;
          cnt_d       = cnt_q + 16'd1;
          state_d     = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StLoad;
      idx_q       <= '0;
      settle_q    <= '0;
      feat_q      <= '0;
      cls_valid_q <= 1'b0;
      cls_data_q  <= '0;
      frame_err_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      settle_q    <= settle_d;
      feat_q      <= feat_d;
      cls_valid_q <= cls_valid_d;
      cls_data_q  <= cls_data_d;
      frame_err_q <= frame_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign feat_ready = (state_q == StLoad);
  assign inp        = feat_q;
  assign cls_valid  = cls_valid_q;
  assign cls_data   = cls_data_q;
  assign frame_err  = frame_err_q;
  assign sample_cnt = cnt_q;

endmodule
